// File: rtl/instruction_encoder_if.sv
// Request and command handshake bundle for the instruction encoder.
interface instruction_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_fmt;
    logic [2:0]  req_opcode;
    logic [31:0] req_src_addr;
    logic [31:0] req_dst_addr;
    logic [31:0] req_param1;
    logic [31:0] req_param2;
    logic [31:0] cmd;
    logic        cmd_valid;
    logic        cmd_ready;

    // Host/sequencer side: issues requests, consumes commands.
    modport master (
        output req_valid, req_fmt, req_opcode, req_src_addr, req_dst_addr,
               req_param1, req_param2, cmd_ready,
        input  req_ready, cmd, cmd_valid
    );

    // Encoder side: accepts requests, issues commands.
    modport slave (
        input  req_valid, req_fmt, req_opcode, req_src_addr, req_dst_addr,
               req_param1, req_param2, cmd_ready,
        output req_ready, cmd, cmd_valid
    );
endinterface

// File: rtl/instruction_encoder.sv
// Range-checks field-level requests, packs them into 32-bit command words,
// buffers them in a small FIFO and issues them over a valid/ready handshake.
module instruction_encoder #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned HOLD_AFTER_XFER = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    instruction_encoder_if.slave         bus,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         err_range,
    input  logic                         err_clear,
    output logic [15:0]                  sent_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_req_ready;
    logic [1:0]    r_state;
    logic [31:0]   r_cmd;
    logic          r_cmd_valid;
    logic          r_err;
    logic [15:0]   r_sent;

    logic          w_accept;
    logic          w_in_range;
    logic [31:0]   w_word;
    logic          w_push;
    logic          w_pop;
    logic          w_xfer;
    logic          w_empty;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_count_nxt;

    assign w_accept = bus.req_valid && r_req_ready;
    assign w_push   = w_accept && w_in_range;
    assign w_empty  = (r_count == '0);

    // Range check and packing of the incoming request.
    always_comb begin
        w_in_range = 1'b0;
        w_word     = '0;
        if (!bus.req_fmt) begin
            w_in_range = (bus.req_src_addr[31:12] == '0) && (bus.req_dst_addr[31:12] == '0);
            w_word     = {bus.req_opcode, bus.req_src_addr[11:0], bus.req_dst_addr[11:0], 5'd0};
        end else begin
            w_in_range = (bus.req_param1[31:16] == '0) && (bus.req_param2[31:13] == '0);
            w_word     = {bus.req_opcode, bus.req_param1[15:0], bus.req_param2[12:0]};
        end
    end

    // Output FSM next-state, pop and transfer decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (bus.cmd_ready) begin
                    w_xfer = 1'b1;
                    if (HOLD_AFTER_XFER != 0) begin
                        w_state_nxt = HOLD;
                    end else if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            HOLD: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = SEND;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next FIFO occupancy; simultaneous push and pop cancel out.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // FIFO pointers, occupancy and registered request ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_req_ready <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count     <= w_count_nxt;
            r_req_ready <= (w_count_nxt != CW'(FIFO_DEPTH));
        end
    end

    // FSM state and registered command outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_sent      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_valid <= (w_state_nxt == SEND);
            if (w_pop)  r_cmd  <= r_mem[r_rd_ptr];
            if (w_xfer) r_sent <= r_sent + 16'd1;
        end
    end

    // Sticky range error; a new violation beats a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_in_range) begin
            r_err <= 1'b1;
        end else if (err_clear) begin
            r_err <= 1'b0;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.cmd       = r_cmd;
    assign bus.cmd_valid = r_cmd_valid;
    assign fifo_count    = r_count;
    assign err_range     = r_err;
    assign sent_count    = r_sent;

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench: a held-transfer instance and a back-to-back instance,
// checked against a queue-based reference model of the command stream.
module tb_instruction_encoder;

    logic        clk;
    logic        rst_n;
    bit          sel;          // 0: HOLD_AFTER_XFER=1 instance, 1: back-to-back instance
    logic        req_valid;
    logic        req_fmt;
    logic [2:0]  req_opcode;
    logic [31:0] req_src_addr;
    logic [31:0] req_dst_addr;
    logic [31:0] req_param1;
    logic [31:0] req_param2;
    logic        cmd_ready;
    logic        err_clear;

    logic [2:0]  fc_h, fc_b;
    logic        err_h, err_b;
    logic [15:0] sc_h, sc_b;

    instruction_encoder_if if_h ();
    instruction_encoder_if if_b ();

    assign if_h.req_valid    = req_valid & ~sel;
    assign if_b.req_valid    = req_valid & sel;
    assign if_h.req_fmt      = req_fmt;
    assign if_b.req_fmt      = req_fmt;
    assign if_h.req_opcode   = req_opcode;
    assign if_b.req_opcode   = req_opcode;
    assign if_h.req_src_addr = req_src_addr;
    assign if_b.req_src_addr = req_src_addr;
    assign if_h.req_dst_addr = req_dst_addr;
    assign if_b.req_dst_addr = req_dst_addr;
    assign if_h.req_param1   = req_param1;
    assign if_b.req_param1   = req_param1;
    assign if_h.req_param2   = req_param2;
    assign if_b.req_param2   = req_param2;
    assign if_h.cmd_ready    = cmd_ready;
    assign if_b.cmd_ready    = cmd_ready;

    instruction_encoder #(.FIFO_DEPTH(4), .HOLD_AFTER_XFER(1)) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (if_h),
        .fifo_count (fc_h),
        .err_range  (err_h),
        .err_clear  (err_clear),
        .sent_count (sc_h)
    );

    instruction_encoder #(.FIFO_DEPTH(4), .HOLD_AFTER_XFER(0)) u_b2b (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (if_b),
        .fifo_count (fc_b),
        .err_range  (err_b),
        .err_clear  (err_clear),
        .sent_count (sc_b)
    );

    // Observed view of whichever instance is active.
    logic [31:0] w_cmd;
    logic        w_cmd_valid;
    logic        w_req_ready;
    logic [2:0]  w_fifo_count;
    logic        w_err_range;
    logic [15:0] w_sent_count;

    assign w_cmd        = sel ? if_b.cmd       : if_h.cmd;
    assign w_cmd_valid  = sel ? if_b.cmd_valid : if_h.cmd_valid;
    assign w_req_ready  = sel ? if_b.req_ready : if_h.req_ready;
    assign w_fifo_count = sel ? fc_b  : fc_h;
    assign w_err_range  = sel ? err_b : err_h;
    assign w_sent_count = sel ? sc_b  : sc_h;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference rules: legality and packed word by plain arithmetic.
    function automatic bit in_range(input logic fmt, input logic [31:0] a, input logic [31:0] b);
        if (!fmt) return (a < 32'd4096) && (b < 32'd4096);
        return (a < 32'd65536) && (b < 32'd8192);
    endfunction

    function automatic logic [31:0] pack(input logic fmt, input logic [2:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
        if (!fmt) return 32'(op) * 32'h2000_0000 + a * 32'h0002_0000 + b * 32'd32;
        return 32'(op) * 32'h2000_0000 + a * 32'h0000_2000 + b;
    endfunction

    // Reference model state.
    logic [31:0] exp_q [$];
    logic        err_m;
    logic [15:0] sent_m;
    logic        prev_valid;
    logic        prev_xfer;
    logic [31:0] prev_cmd;
    logic        xfer;
    logic        acc;

    // Monitor: compare outputs with the model, then apply the upcoming edge's events.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            err_m      = 1'b0;
            sent_m     = 16'd0;
            prev_valid = 1'b0;
            prev_xfer  = 1'b0;
            prev_cmd   = 32'd0;
        end else begin
            check_eq("err_range", 32'(w_err_range), 32'(err_m));
            check_eq("sent_count", 32'(w_sent_count), 32'(sent_m));
            if (prev_valid && !prev_xfer) begin
                check_eq("stall_valid", 32'(w_cmd_valid), 32'd1);
                check_eq("stall_cmd", w_cmd, prev_cmd);
            end
            if (prev_xfer && !sel) begin
                check_eq("hold_valid", 32'(w_cmd_valid), 32'd0);
                check_eq("hold_cmd", w_cmd, prev_cmd);
            end
            xfer = w_cmd_valid && cmd_ready;
            if (xfer) begin
                if (exp_q.size() == 0) check_eq("xfer_queue_nonempty", 32'(exp_q.size()), 32'd1);
                else check_eq("cmd_word", w_cmd, exp_q.pop_front());
                sent_m = sent_m + 16'd1;
            end
            acc = req_valid && w_req_ready;
            if (acc && in_range(req_fmt, req_fmt ? req_param1 : req_src_addr,
                                req_fmt ? req_param2 : req_dst_addr))
                exp_q.push_back(pack(req_fmt, req_opcode,
                                     req_fmt ? req_param1 : req_src_addr,
                                     req_fmt ? req_param2 : req_dst_addr));
            if (acc && !in_range(req_fmt, req_fmt ? req_param1 : req_src_addr,
                                 req_fmt ? req_param2 : req_dst_addr))
                err_m = 1'b1;
            else if (err_clear)
                err_m = 1'b0;
            prev_valid = w_cmd_valid;
            prev_xfer  = xfer;
            prev_cmd   = w_cmd;
        end
    end

    task automatic set_req(input logic fmt, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_fmt    = fmt;
        req_opcode = op;
        if (!fmt) begin
            req_src_addr = a;
            req_dst_addr = b;
            req_param1   = $urandom;
            req_param2   = $urandom;
        end else begin
            req_param1   = a;
            req_param2   = b;
            req_src_addr = $urandom;
            req_dst_addr = $urandom;
        end
    endtask

    task automatic gen_fields(input bit allow_bad);
        logic        fmt;
        logic [31:0] a, b;
        fmt = 1'($urandom_range(0, 1));
        if (!fmt) begin
            a = 32'($urandom_range(0, 4095));
            b = 32'($urandom_range(0, 4095));
        end else begin
            a = 32'($urandom_range(0, 65535));
            b = 32'($urandom_range(0, 8191));
        end
        if (allow_bad && $urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) a = $urandom | (fmt ? 32'h0001_0000 : 32'h0000_1000);
            else                           b = $urandom | (fmt ? 32'h0000_2000 : 32'h0000_1000);
        end
        set_req(fmt, 3'($urandom_range(0, 7)), a, b);
    endtask

    // Present the current request and hold it until accepted (bounded).
    task automatic issue();
        int n;
        n = 0;
        req_valid = 1'b1;
        @(negedge clk);
        while (!w_req_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!w_req_ready) check_eq("accept_timeout", 32'(w_req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        cmd_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !w_cmd_valid) break;
        end
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
        check_eq("drain_idle", 32'(w_cmd_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic rand_phase(input int unsigned nreq);
        int unsigned done, cyc;
        logic        a;
        done = 0;
        cyc  = 0;
        req_valid = 1'b0;
        while (done < nreq && cyc < 6000) begin
            cmd_ready = ($urandom_range(0, 3) != 0);
            err_clear = ($urandom_range(0, 15) == 0);
            if (!req_valid && $urandom_range(0, 1) == 1) begin
                gen_fields(1'b1);
                req_valid = 1'b1;
            end
            @(negedge clk);
            a = req_valid && w_req_ready;
            if (a) done++;
            @(posedge clk); #1;
            if (a) req_valid = 1'b0;
            cyc++;
        end
        req_valid = 1'b0;
        err_clear = 1'b0;
        check_eq("rand_reqs_done", done, nreq);
        drain();
    endtask

    // Queue three words behind a stalled output, release, record cmd_valid.
    task automatic pattern_test(input string tag, input int unsigned nbits, input logic [7:0] exp_pat);
        logic [7:0] pat;
        pat = 8'd0;
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            gen_fields(1'b0);
            issue();
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("pattern_pre_valid", 32'(w_cmd_valid), 32'd1);
        cmd_ready = 1'b1;
        for (int i = 0; i < int'(nbits); i++) begin
            @(negedge clk);
            pat = {pat[6:0], w_cmd_valid};
        end
        check_eq(tag, 32'(pat), 32'(exp_pat));
        drain();
    endtask

    task automatic do_reset(input bit new_sel);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sel   = new_sel;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        sel       = 1'b0;
        req_valid = 1'b0;
        cmd_ready = 1'b0;
        err_clear = 1'b0;
        set_req(1'b0, 3'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 32'(w_req_ready), 32'd1);
        check_eq("rst_cmd", w_cmd, 32'd0);
        check_eq("rst_cmd_valid", 32'(w_cmd_valid), 32'd0);
        check_eq("rst_fifo_count", 32'(w_fifo_count), 32'd0);
        check_eq("rst_err_range", 32'(w_err_range), 32'd0);
        check_eq("rst_sent_count", 32'(w_sent_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Address-form packing and two-cycle latency.
        cmd_ready = 1'b1;
        set_req(1'b0, 3'b101, 32'h123, 32'h456);
        issue();
        check_eq("lat_e0_valid", 32'(w_cmd_valid), 32'd0);
        check_eq("lat_e0_count", 32'(w_fifo_count), 32'd1);
        @(posedge clk); #1;
        check_eq("lat_e1_valid", 32'(w_cmd_valid), 32'd1);
        check_eq("addr_cmd", w_cmd, 32'hA246_8AC0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("addr_sent", 32'(w_sent_count), 32'd1);
        check_eq("cmd_retained", w_cmd, 32'hA246_8AC0);

        // Parameter-form packing.
        set_req(1'b1, 3'b010, 32'hBEEF, 32'h1ABC);
        issue();
        @(posedge clk); #1;
        check_eq("param_valid", 32'(w_cmd_valid), 32'd1);
        check_eq("param_cmd", w_cmd, 32'h57DD_FABC);
        drain();

        // Out-of-range requests are accepted, dropped and flagged.
        set_req(1'b0, 3'd1, 32'h1000, 32'h10);
        issue();
        set_req(1'b1, 3'd2, 32'h10, 32'h2000);
        issue();
        repeat (3) @(posedge clk);
        #1;
        check_eq("oor_no_valid", 32'(w_cmd_valid), 32'd0);
        check_eq("oor_err_set", 32'(w_err_range), 32'd1);
        err_clear = 1'b1;
        set_req(1'b0, 3'd3, 32'h10, 32'hFFFF);
        issue();
        err_clear = 1'b0;
        check_eq("oor_set_beats_clear", 32'(w_err_range), 32'd1);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        check_eq("oor_err_cleared", 32'(w_err_range), 32'd0);

        // Stall: five words fill output stage plus FIFO, then release in order.
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            gen_fields(1'b0);
            issue();
        end
        check_eq("full_req_ready", 32'(w_req_ready), 32'd0);
        check_eq("full_fifo_count", 32'(w_fifo_count), 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("full_ready_low", 32'(w_req_ready), 32'd0);
        end
        drain();

        // Held-transfer valid pattern and randomized traffic.
        pattern_test("hold_pattern", 6, 8'b0010_1010);
        rand_phase(150);

        // Back-to-back instance.
        do_reset(1'b1);
        check_eq("b2b_rst_ready", 32'(w_req_ready), 32'd1);
        pattern_test("b2b_pattern", 4, 8'b0000_1110);
        rand_phase(150);

        // Reset in the middle of operation.
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            gen_fields(1'b0);
            issue();
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("mid_pre_valid", 32'(w_cmd_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(w_cmd_valid), 32'd0);
        check_eq("mid_rst_count", 32'(w_fifo_count), 32'd0);
        check_eq("mid_rst_sent", 32'(w_sent_count), 32'd0);
        check_eq("mid_rst_ready", 32'(w_req_ready), 32'd1);
        check_eq("mid_rst_cmd", w_cmd, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
